// File: rtl/xgpon_burst_deframer.sv
// xgpon_burst_deframer: hunts the burst delimiter in the raw RX word stream and
// forwards payload words as an AXI4-Stream burst through a fall-through FIFO.
module xgpon_burst_deframer #(
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_WORDS  = 512,
  parameter int DELIM_TOL  = 2
) (
  input  logic        axis_clk,
  input  logic        axis_resetn,
  input  logic        enable,
  input  logic [31:0] rx_data,
  input  logic        rx_valid,
  input  logic [31:0] delim_pattern,
  input  logic [31:0] frtrail_pattern,
  output logic [31:0] axis_TDATA_out,
  output logic        axis_TVALID_out,
  output logic [3:0]  axis_TKEEP_out,
  output logic        axis_TLAST_out,
  output logic        axis_TUSER_out,
  input  logic        axis_TREADY_in,
  output logic [15:0] burst_count,
  output logic [15:0] err_count,
  output logic        overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(MAX_WORDS + 1);
  localparam logic [CW-1:0] MAXW = CW'(MAX_WORDS);
  typedef enum logic {HUNT, PAYLOAD} state_t;
  state_t state, state_nx;
  logic hold_v, hold_v_nx;
  logic [31:0] hold_d, hold_d_nx;
  logic [CW-1:0] wcnt, wcnt_nx;
  logic wr_req, wr_last, wr_user, inc_b, inc_e;
  logic delim_hit, trail_hit;
  logic [33:0] mem [FIFO_DEPTH];
  logic [33:0] head;
  logic [AW:0] wp, rp;
  logic full, empty, push, pop;
  assign delim_hit = $countones(rx_data ^ delim_pattern) <= DELIM_TOL;
  assign trail_hit = rx_data == frtrail_pattern;
  // The hold register delays each payload word by one so the trailer can mark it TLAST.
  always_comb begin
    state_nx = state;
    hold_v_nx = hold_v;
    hold_d_nx = hold_d;
    wcnt_nx = wcnt;
    wr_req = 1'b0;
    wr_last = 1'b0;
    wr_user = 1'b0;
    inc_b = 1'b0;
    inc_e = 1'b0;
    if (!enable) begin
      state_nx = HUNT;
      hold_v_nx = 1'b0;
      if (state == PAYLOAD && hold_v) begin
        wr_req = 1'b1;
        wr_last = 1'b1;
        wr_user = 1'b1;
        inc_e = 1'b1;
      end
    end else if (state == HUNT) begin
      if (rx_valid && delim_hit) begin
        state_nx = PAYLOAD;
        hold_v_nx = 1'b0;
        wcnt_nx = '0;
      end
    end else if (rx_valid) begin
      if (trail_hit) begin
        state_nx = HUNT;
        hold_v_nx = 1'b0;
        wr_req = hold_v;
        wr_last = 1'b1;
        inc_b = hold_v;
      end else if (wcnt == MAXW) begin
        state_nx = HUNT;
        hold_v_nx = 1'b0;
        wr_req = hold_v;
        wr_last = 1'b1;
        wr_user = 1'b1;
        inc_e = hold_v;
      end else begin
        wr_req = hold_v;
        hold_v_nx = 1'b1;
        hold_d_nx = rx_data;
        wcnt_nx = wcnt + 1'b1;
      end
    end
  end
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign push = wr_req && !full;
  assign pop = !empty && axis_TREADY_in;
  assign head = mem[rp[AW-1:0]];
  assign axis_TVALID_out = !empty;
  assign axis_TDATA_out = empty ? '0 : head[31:0];
  assign axis_TLAST_out = !empty && head[33];
  assign axis_TUSER_out = !empty && head[32];
  assign axis_TKEEP_out = {4{!empty}};
  always_ff @(posedge axis_clk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state <= HUNT;
      hold_v <= 1'b0;
      hold_d <= '0;
      wcnt <= '0;
      wp <= '0;
      rp <= '0;
      burst_count <= '0;
      err_count <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      hold_v <= hold_v_nx;
      hold_d <= hold_d_nx;
      wcnt <= wcnt_nx;
      wp <= wp + (AW+1)'(push);
      rp <= rp + (AW+1)'(pop);
      burst_count <= burst_count + 16'(inc_b);
      err_count <= err_count + 16'(inc_e);
      overflow <= overflow | (wr_req & full);
    end
  end
  always_ff @(posedge axis_clk) begin
    if (push) mem[wp[AW-1:0]] <= {wr_last, wr_user, hold_d};
  end
endmodule

// File: tb/tb_xgpon_burst_deframer.sv
// tb_xgpon_burst_deframer: directed bursts with a scoreboard of expected output
// beats, checked by immediate assertions one tick before each clock edge.
module tb_xgpon_burst_deframer;
  localparam logic [31:0] DELIM = 32'hB2C50FA1;
  localparam logic [31:0] TRAIL = 32'h82D6F416;
  logic clk = 1'b0;
  logic resetn, enable, rx_valid, tready;
  logic [31:0] rx_data, tdata;
  logic tvalid, tlast, tuser, ovf;
  logic [3:0] tkeep;
  logic [15:0] bcnt, ecnt;
  typedef struct {logic [31:0] d; logic l; logic u;} exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  logic prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  always #5 clk = ~clk;
  xgpon_burst_deframer #(.FIFO_DEPTH(16), .MAX_WORDS(40), .DELIM_TOL(2)) dut (
    .axis_clk(clk), .axis_resetn(resetn), .enable(enable),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .delim_pattern(DELIM), .frtrail_pattern(TRAIL),
    .axis_TDATA_out(tdata), .axis_TVALID_out(tvalid), .axis_TKEEP_out(tkeep),
    .axis_TLAST_out(tlast), .axis_TUSER_out(tuser), .axis_TREADY_in(tready),
    .burst_count(bcnt), .err_count(ecnt), .overflow(ovf)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic mon();
    exp_t e;
    if (prev_stall && tvalid) chk("tdata_stable", tdata, prev_data);
    if (q.size() == 0) chk("idle_tvalid", 32'(tvalid), 0);
    else if (tvalid && tready) begin
      e = q.pop_front();
      chk("tdata", tdata, e.d);
      chk("tlast", 32'(tlast), 32'(e.l));
      chk("tuser", 32'(tuser), 32'(e.u));
      chk("tkeep", 32'(tkeep), 32'hF);
    end
    prev_stall = tvalid && !tready;
    prev_data = tdata;
  endtask
  task automatic step(input logic v, input logic [31:0] d);
    rx_valid = v;
    rx_data = d;
    #4;
    mon();
    @(negedge clk);
  endtask
  task automatic exp_w(input logic [31:0] d, input logic l, input logic u);
    q.push_back('{d, l, u});
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      step(1'b0, '0);
      n++;
    end
    chk("drain_timeout", q.size(), 0);
    repeat (3) step(1'b0, '0);
  endtask
  initial begin
    resetn = 1'b0;
    enable = 1'b0;
    rx_valid = 1'b0;
    rx_data = '0;
    tready = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    chk("rst_tvalid", 32'(tvalid), 0);
    chk("rst_tkeep", 32'(tkeep), 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_tlast", 32'({tlast, tuser}), 0);
    chk("rst_counts", {bcnt, ecnt}, 0);
    chk("rst_overflow", 32'(ovf), 0);
    enable = 1'b1;
    tready = 1'b1;
    // nominal burst with idle and preamble words ahead of the delimiter
    repeat (3) step(1'b1, 32'h0);
    repeat (3) step(1'b1, 32'h05560556);
    step(1'b1, DELIM);
    for (int i = 1; i <= 8; i++) begin
      exp_w(32'(i), i == 8, 1'b0);
      step(1'b1, 32'(i));
    end
    step(1'b1, TRAIL);
    drain();
    chk("nominal_bursts", 32'(bcnt), 1);
    chk("nominal_errs", 32'(ecnt), 0);
    // delimiter with 2 bit errors accepted, 3 bit errors rejected
    step(1'b1, DELIM ^ 32'h3);
    for (int i = 1; i <= 3; i++) begin
      exp_w(32'h100 + 32'(i), i == 3, 1'b0);
      step(1'b1, 32'h100 + 32'(i));
    end
    step(1'b1, TRAIL);
    drain();
    step(1'b1, DELIM ^ 32'h7);
    for (int i = 1; i <= 3; i++) step(1'b1, 32'h200 + 32'(i));
    step(1'b1, TRAIL);
    drain();
    chk("tol_bursts", 32'(bcnt), 2);
    chk("tol_errs", 32'(ecnt), 0);
    // zero-length burst, then a normal one straight after
    step(1'b1, DELIM);
    step(1'b1, TRAIL);
    step(1'b1, DELIM);
    for (int i = 1; i <= 2; i++) begin
      exp_w(32'h300 + 32'(i), i == 2, 1'b0);
      step(1'b1, 32'h300 + 32'(i));
    end
    step(1'b1, TRAIL);
    drain();
    chk("zero_len_bursts", 32'(bcnt), 3);
    // forced close at MAX_WORDS, remaining words and trailer ignored
    step(1'b1, DELIM);
    for (int i = 1; i <= 44; i++) begin
      if (i <= 40) exp_w(32'h1000 + 32'(i), i == 40, i == 40);
      step(1'b1, 32'h1000 + 32'(i));
    end
    step(1'b1, TRAIL);
    drain();
    chk("max_errs", 32'(ecnt), 1);
    chk("max_bursts", 32'(bcnt), 3);
    chk("pre_overflow", 32'(ovf), 0);
    // 40-cycle stall during a 32-word burst: only the first 16 words fit
    tready = 1'b0;
    step(1'b1, DELIM);
    for (int i = 1; i <= 32; i++) begin
      if (i <= 16) exp_w(32'h2000 + 32'(i), 1'b0, 1'b0);
      step(1'b1, 32'h2000 + 32'(i));
    end
    step(1'b1, TRAIL);
    repeat (6) step(1'b0, '0);
    chk("bp_overflow", 32'(ovf), 1);
    tready = 1'b1;
    drain();
    chk("bp_bursts", 32'(bcnt), 4);
    // enable dropped after word 5
    step(1'b1, DELIM);
    for (int i = 1; i <= 5; i++) begin
      exp_w(32'h3000 + 32'(i), i == 5, i == 5);
      step(1'b1, 32'h3000 + 32'(i));
    end
    enable = 1'b0;
    step(1'b1, 32'h3006);
    step(1'b1, DELIM);
    enable = 1'b1;
    drain();
    chk("en_errs", 32'(ecnt), 2);
    chk("en_bursts", 32'(bcnt), 4);
    // asynchronous reset pulse mid-burst with words waiting in the FIFO
    tready = 1'b0;
    step(1'b1, DELIM);
    for (int i = 1; i <= 3; i++) begin
      if (i <= 2) exp_w(32'h4000 + 32'(i), 1'b0, 1'b0);
      step(1'b1, 32'h4000 + 32'(i));
    end
    chk("pre_rst_tvalid", 32'(tvalid), 1);
    resetn = 1'b0;
    #1;
    chk("arst_tvalid", 32'(tvalid), 0);
    chk("arst_tkeep", 32'(tkeep), 0);
    chk("arst_counts", {bcnt, ecnt}, 0);
    chk("arst_overflow", 32'(ovf), 0);
    q.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    tready = 1'b1;
    // words before a delimiter are discarded after reset, then a clean burst
    step(1'b1, 32'h4004);
    step(1'b1, DELIM);
    for (int i = 1; i <= 2; i++) begin
      exp_w(32'h5000 + 32'(i), i == 2, 1'b0);
      step(1'b1, 32'h5000 + 32'(i));
    end
    step(1'b1, TRAIL);
    drain();
    chk("post_rst_bursts", 32'(bcnt), 1);
    chk("post_rst_errs", 32'(ecnt), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
